multi_ff_bank: RTL
==================

MULTI_FF_BANK -- requirements
Module: multi_ff_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of storage bits in the bank (legal 1..32).
REQ-002 Parameter RESET_VAL, default all-zeros WIDTH bits, value loaded into q on reset.
REQ-003 Parameter COLL_POL, default 0, SR-mode collision policy: 0 hold, 1 set, 2 clear (3 treated as 0).
REQ-004 Parameter CNT_W, default 8, width of collision counter.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 en  input  1  update enable; 0 = whole bank holds.
REQ-008 mode  input  2  bank mode: 00 SR, 01 JK, 10 D, 11 T.
REQ-009 a  input  WIDTH  per-bit primary input (S / J / D / T).
REQ-010 b  input  WIDTH  per-bit secondary input (R / K; ignored in D and T).
REQ-011 clr_flag  input  1  clears sticky collision flag and counter.
REQ-012 q  output  WIDTH  registered state.
REQ-013 qb  output  WIDTH  combinational ~q, always.
REQ-014 coll_mask  output  WIDTH  registered mask of bits with a&b in last enabled SR-mode cycle.
REQ-015 coll_flag  output  1  sticky: at least one SR collision since last clear/reset.
REQ-016 coll_cnt  output  CNT_W  saturating count of collision cycles.

Function
REQ-017 en=0: q, coll_mask, coll_flag, coll_cnt hold (clr_flag still honoured); no collision counted.
REQ-018 en=1, mode SR, per bit {a,b}: 00 hold, 10 q<=1, 01 q<=0, 11 per COLL_POL (never X).
REQ-019 en=1, mode JK, per bit {a,b}: 00 hold, 10 q<=1, 01 q<=0, 11 q<=~q.
REQ-020 en=1, mode D: q<=a next edge; b ignored.
REQ-021 en=1, mode T: bit toggles where a=1, holds where a=0; b ignored.
REQ-022 Latency: one clk edge from input sample to q; qb follows q in same cycle.
REQ-023 Collision cycle: en=1, mode=SR, (a&b)!=0; counts once per cycle regardless of colliding bit count.
REQ-024 On enabled SR cycle coll_mask<=a&b; on enabled non-SR cycle coll_mask<=0.
REQ-025 Collision cycle sets coll_flag=1 and increments coll_cnt; at all-ones coll_cnt holds (saturates, no wrap).
REQ-026 clr_flag=1 (no collision same cycle): coll_flag<=0, coll_cnt<=0.
REQ-027 clr_flag=1 and collision same cycle: coll_flag<=1, coll_cnt<=1 (set wins over clear).
REQ-028 Mode change takes effect on the cycle presented; no pipeline, no mode-change penalty.
REQ-029 Bits are independent; no cross-bit interaction except shared counter/flag.

Reset
REQ-030 rst=1 at rising edge: q<=RESET_VAL, coll_mask<=0, coll_flag<=0, coll_cnt<=0; overrides en, mode, clr_flag.
REQ-031 First edge after rst deasserts applies normal function from REQ-017..REQ-029.

Configuration
REQ-032 Macro MULTI_FF_BANK_ASSERT_EN defined: module contains concurrent assertions, disabled during rst, checking REQ-018..REQ-021, REQ-025 saturation, REQ-030, and q never X/Z after reset; failures report via $error.
REQ-033 Macro undefined: no assertions compiled; functional behaviour identical.

Verification (WIDTH=8, RESET_VAL=8'h00, COLL_POL=0, CNT_W=8)
REQ-034 rst=1 one edge with en=1, mode=D, a=8'hFF -> q=8'h00, qb=8'hFF, coll_flag=0, coll_cnt=0.
REQ-035 mode=SR, en=1, q=8'h0F, a=8'hF0, b=8'h03 -> q=8'hFC, coll_mask=0, flag 0; then a=8'h81,b=8'h81 -> q=8'hFC, coll_mask=8'h81, coll_flag=1, coll_cnt=1.
REQ-036 mode=JK, q=8'hAA, a=b=8'hFF -> q=8'h55; mode=T, a=8'h0F -> q=8'h5A; mode=D, a=8'h3C -> q=8'h3C.
REQ-037 en=0 with mode=SR, a=b=8'hFF for 3 cycles -> q unchanged, coll_cnt unchanged, coll_mask unchanged.
REQ-038 300 consecutive SR collision cycles -> coll_cnt=8'hFF stays; then clr_flag with collision -> flag=1, cnt=1; clr_flag alone -> flag=0, cnt=0.
REQ-039 COLL_POL=1 and COLL_POL=2 builds, a=b=8'hFF from q=8'h00 -> q=8'hFF and q=8'h00 respectively.

Source files
------------

// File: rtl/multi_ff_bank.sv
// Bank of WIDTH flip-flops switchable between SR, JK, D and T behaviour,
// with SR collision tracking. Define MULTI_FF_BANK_ASSERT_EN to compile the built-in assertions.
module multi_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               COLL_POL  = 0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] coll_mask,
  output logic             coll_flag,
  output logic [CNT_W-1:0] coll_cnt
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] coll_mask_reg;
  logic             coll_flag_reg;
  logic [CNT_W-1:0] coll_cnt_reg;
  logic             coll_cycle;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic bit_next;
      always_comb begin
        bit_next = q_reg[gi];
        case (mode)
          MODE_SR: begin
            case ({a[gi], b[gi]})
              2'b10:   bit_next = 1'b1;
              2'b01:   bit_next = 1'b0;
              2'b11: begin
                // Policy 3 (and anything unexpected) falls back to hold.
                if (COLL_POL == 1)      bit_next = 1'b1;
                else if (COLL_POL == 2) bit_next = 1'b0;
                else                    bit_next = q_reg[gi];
              end
              default: bit_next = q_reg[gi];
            endcase
          end
          MODE_JK: begin
            case ({a[gi], b[gi]})
              2'b10:   bit_next = 1'b1;
              2'b01:   bit_next = 1'b0;
              2'b11:   bit_next = ~q_reg[gi];
              default: bit_next = q_reg[gi];
            endcase
          end
          MODE_D:  bit_next = a[gi];
          default: bit_next = q_reg[gi] ^ a[gi];
        endcase
      end
      assign q_next[gi] = bit_next;
    end
  endgenerate

  assign coll_cycle = en && (mode == MODE_SR) && ((a & b) != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg         <= RESET_VAL;
      coll_mask_reg <= '0;
      coll_flag_reg <= 1'b0;
      coll_cnt_reg  <= '0;
    end else begin
      if (en) begin
        q_reg         <= q_next;
        coll_mask_reg <= (mode == MODE_SR) ? (a & b) : '0;
      end
      // A collision in the same cycle as a clear restarts the count at one.
      if (coll_cycle) begin
        coll_flag_reg <= 1'b1;
        if (clr_flag)
          coll_cnt_reg <= CNT_W'(1);
        else if (coll_cnt_reg != '1)
          coll_cnt_reg <= coll_cnt_reg + CNT_W'(1);
      end else if (clr_flag) begin
        coll_flag_reg <= 1'b0;
        coll_cnt_reg  <= '0;
      end
    end
  end

  assign q         = q_reg;
  assign qb        = ~q_reg;
  assign coll_mask = coll_mask_reg;
  assign coll_flag = coll_flag_reg;
  assign coll_cnt  = coll_cnt_reg;

`ifdef MULTI_FF_BANK_ASSERT_EN
  logic seen_rst_reg;
  always_ff @(posedge clk) begin
    if (rst) seen_rst_reg <= 1'b1;
  end

  a_reset: assert property (@(posedge clk) rst |=>
      (q == RESET_VAL) && (coll_mask == '0) && !coll_flag && (coll_cnt == '0))
    else $error("reset state wrong");
  a_d_mode: assert property (@(posedge clk) disable iff (rst)
      en && mode == MODE_D |=> q == $past(a))
    else $error("D mode update wrong");
  a_t_mode: assert property (@(posedge clk) disable iff (rst)
      en && mode == MODE_T |=> q == ($past(q) ^ $past(a)))
    else $error("T mode update wrong");
  a_cnt_sat: assert property (@(posedge clk) disable iff (rst)
      coll_cnt == '1 && !clr_flag |=> coll_cnt == '1)
    else $error("collision counter wrapped");
  a_no_x: assert property (@(posedge clk) !rst && seen_rst_reg |-> !$isunknown(q))
    else $error("q unknown after reset");

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chk
      a_set: assert property (@(posedge clk) disable iff (rst)
          en && !mode[1] && a[gi] && !b[gi] |=> q[gi])
        else $error("SR/JK set wrong");
      a_clr: assert property (@(posedge clk) disable iff (rst)
          en && !mode[1] && !a[gi] && b[gi] |=> !q[gi])
        else $error("SR/JK clear wrong");
      a_hold: assert property (@(posedge clk) disable iff (rst)
          en && !mode[1] && !a[gi] && !b[gi] |=> q[gi] == $past(q[gi]))
        else $error("SR/JK hold wrong");
      a_jk_tog: assert property (@(posedge clk) disable iff (rst)
          en && mode == MODE_JK && a[gi] && b[gi] |=> q[gi] != $past(q[gi]))
        else $error("JK toggle wrong");
      a_sr_coll: assert property (@(posedge clk) disable iff (rst)
          en && mode == MODE_SR && a[gi] && b[gi] |=>
          q[gi] == ((COLL_POL == 1) ? 1'b1 : (COLL_POL == 2) ? 1'b0 : $past(q[gi])))
        else $error("SR collision policy wrong");
    end
  endgenerate
`endif

endmodule
